mem_req_arbiter: RTL

Round-robin arbiter that shares one memory request port among `NUM_REQ` requesters. It issues granted requests through a registered valid/ready interface and returns in-order responses to the requester that issued each one. A small ID FIFO tracks outstanding transactions. The block sits between the requester-side agents and the single memory port, with address and data widths taken from `common_pkg`.

---
 rtl/common_pkg.sv | 14 +
 rtl/arb_id_fifo.sv | 53 +++++
 rtl/mem_req_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared widths and types for the memory request path and its arbiter.
package common_pkg;
  localparam int ADDR_WIDTH          = 32;
  localparam int DATA_WIDTH          = 64;
  localparam int MAX_TRANS           = 8;
  localparam int ARB_MAX_OUTSTANDING = 8;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_e;

  typedef logic [2:0] req_id_t;
endpackage

// File: rtl/arb_id_fifo.sv
// Synchronous FIFO of requester IDs, one entry per outstanding memory transaction.
module arb_id_fifo
  import common_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  req_id_t          push_id,
  input  logic             pop,
  output req_id_t          head_id,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  req_id_t          slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop on an empty FIFO is ignored; a push while full is taken only alongside a real pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign head_id = slots[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request port among NUM_REQ requesters, with
// in-order response routing. Define MEM_ARB_STATS_EN to add per-requester grant counters.
module mem_req_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = common_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH      = common_pkg::DATA_WIDTH,
  parameter int MAX_OUTSTANDING = common_pkg::ARB_MAX_OUTSTANDING,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1
)(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic                          mem_valid,
  input  logic                          mem_ready,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_we,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic                          mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]         mem_rsp_data,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [CNT_W-1:0]              outstanding,
  output logic                          err_unexpected_rsp
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         grant_cnt
`endif
);
  import common_pkg::*;

  arb_state_e            state;
  req_id_t               rr_ptr;
  req_id_t               grant_id;
  req_id_t               pick_id;
  req_id_t               head_id;
  logic                  pick_found;
  logic                  grant;
  logic                  push;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [ADDR_WIDTH-1:0] pick_addr;
  logic                  pick_we;
  logic [DATA_WIDTH-1:0] pick_wdata;
  int                    best_dist;

  function automatic logic [NUM_REQ-1:0] id_onehot(input req_id_t id);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REQ; i++) oh[i] = (id == req_id_t'(i));
    return oh;
  endfunction

  // Rotating priority: the valid requester with the smallest distance from rr_ptr wins.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    best_dist  = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && ((i + NUM_REQ - int'(rr_ptr)) % NUM_REQ) < best_dist) begin
        best_dist  = (i + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
        pick_id    = req_id_t'(i);
        pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    pick_addr  = '0;
    pick_we    = 1'b0;
    pick_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_id == req_id_t'(i)) begin
        pick_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        pick_we    = req_we[i];
        pick_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant     = !rst && (state == ARB_IDLE) && pick_found && !fifo_full;
  assign req_ready = grant ? id_onehot(pick_id) : '0;
  assign push      = (state == ARB_ISSUE) && mem_ready;

  // Grant stage: payload captured on grant, held until the memory port accepts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      grant_id  <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (grant) begin
            mem_addr  <= pick_addr;
            mem_we    <= pick_we;
            mem_wdata <= pick_wdata;
            grant_id  <= pick_id;
            mem_valid <= 1'b1;
            state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            rr_ptr    <= (grant_id == req_id_t'(NUM_REQ - 1)) ? '0 : grant_id + req_id_t'(1);
            state     <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  arb_id_fifo #(
    .DEPTH   (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (grant_id),
    .pop     (mem_rsp_valid),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (outstanding)
  );

  // Response stage: route to the oldest outstanding owner; responses with no owner are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid          <= '0;
      rsp_data           <= '0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      rsp_valid <= (mem_rsp_valid && !fifo_empty) ? id_onehot(head_id) : '0;
      if (mem_rsp_valid && !fifo_empty) rsp_data <= mem_rsp_data;
      if (mem_rsp_valid && fifo_empty) err_unexpected_rsp <= 1'b1;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rst) begin
        grant_cnt_q[i] <= '0;
      end else if (push && (grant_id == req_id_t'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
        grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = grant_cnt_q[i];
  end
`endif

endmodule
